// File: rtl/game_turn_ctrl_pkg.sv
// Shared definitions for the ring turn controller.
// Contents:
//   state_t  - controller state encoding (IDLE=0, TURN=1, OVER=2)
//   LOSE_*   - loss-cause codes driven on lose_cause
//   clog2    - ceiling log2 with a floor of 1, used to size player indices
//              and move fields
package game_turn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TURN = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam logic [1:0] LOSE_NONE    = 2'b00;
  localparam logic [1:0] LOSE_ILLEGAL = 2'b01;
  localparam logic [1:0] LOSE_WRONG   = 2'b10;
  localparam logic [1:0] LOSE_TIMEOUT = 2'b11;

  // A width of at least one bit keeps degenerate parameter values legal.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result++;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/game_turn_ctrl_if.sv
// Player-side bus of the turn controller.
// Inputs to the controller:  start, first_player, press, move
// Outputs of the controller: cur_player, turn_valid, game_over, loser,
//                            lose_cause, move_count, state_out
// Modports: master = stimulus / button logic side, slave = controller.
interface game_turn_ctrl_if
  import game_turn_ctrl_pkg::*;
#(
  parameter int N_PLAYERS = 6,
  parameter int MAX_STEP  = 2,
  parameter int CNT_W     = 8
);

  localparam int PW = clog2(N_PLAYERS);
  localparam int MW = 1 + clog2(MAX_STEP + 1);

  logic                    start;
  logic [PW-1:0]           first_player;
  logic [N_PLAYERS-1:0]    press;
  logic [N_PLAYERS*MW-1:0] move;

  logic [PW-1:0]           cur_player;
  logic                    turn_valid;
  logic                    game_over;
  logic [PW-1:0]           loser;
  logic [1:0]              lose_cause;
  logic [CNT_W-1:0]        move_count;
  logic [1:0]              state_out;

  modport master (
    output start, first_player, press, move,
    input  cur_player, turn_valid, game_over, loser, lose_cause,
           move_count, state_out
  );

  modport slave (
    input  start, first_player, press, move,
    output cur_player, turn_valid, game_over, loser, lose_cause,
           move_count, state_out
  );

endinterface

// File: rtl/game_turn_ctrl_timer.sv
// Per-turn idle timer.
// Ports: clk, reset_n (async active-low), clear (restart from 0),
//        enable (a TURN cycle without a press by the current player),
//        expire (this enabled cycle is the last allowed one).
// TIMEOUT = 0 disables the timer: expire is constant 0.
module game_turn_timer
  import game_turn_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int            TW   = clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TW-1:0] count;

  // Counts idle cycles; parks on LAST so a disabled or stale count never wraps.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/game_turn_ctrl.sv
// N-player ring turn controller. Each legal press by the current player
// passes the turn forward or back by a signed step; a wrong-turn press,
// an illegal step or an idle timeout ends the game.
// Ports: clk, reset_n (async active-low), bus (game_turn_ctrl_if.slave)
//   bus inputs : start, first_player, press[N], move[N*MW]
//   bus outputs: cur_player, turn_valid, game_over, loser, lose_cause,
//                move_count, state_out (all registered)
module game_turn_ctrl
  import game_turn_ctrl_pkg::*;
#(
  parameter int N_PLAYERS = 6,
  parameter int MAX_STEP  = 2,
  parameter int TIMEOUT   = 16,
  parameter int CNT_W     = 8
) (
  input  logic clk,
  input  logic reset_n,
  game_turn_ctrl_if.slave bus
);

  localparam int          PW    = clog2(N_PLAYERS);
  localparam int          MW    = 1 + clog2(MAX_STEP + 1);
  localparam int          AW    = MW - 1;
  localparam logic [PW:0] N_EXT = (PW + 1)'(N_PLAYERS);

  state_t           state_q;
  logic [PW-1:0]    cur_q;
  logic             turn_valid_q;
  logic             game_over_q;
  logic [PW-1:0]    loser_q;
  logic [1:0]       cause_q;
  logic [CNT_W-1:0] count_q;

  logic [MW-1:0]        cur_code;
  logic                 own_press;
  logic [N_PLAYERS-1:0] wrong;
  logic                 wrong_any;
  logic [PW-1:0]        wrong_idx;
  logic [AW-1:0]        mag;
  logic                 legal;
  logic [PW:0]          sum;
  logic [PW-1:0]        next_player;
  logic [PW-1:0]        start_player;
  logic                 move_ok;
  logic                 timer_clear;
  logic                 timer_enable;
  logic                 timer_expire;

  // Move decode, wrong-turn detection and ring addition for the current player.
  always_comb begin
    cur_code  = '0;
    own_press = 1'b0;
    wrong     = '0;
    wrong_idx = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      if (PW'(i) == cur_q) begin
        cur_code  = bus.move[i*MW +: MW];
        own_press = bus.press[i];
      end else begin
        wrong[i] = bus.press[i];
      end
    end
    // Scanning downward leaves the lowest offending index in wrong_idx.
    for (int i = N_PLAYERS - 1; i >= 0; i--) begin
      if (wrong[i]) wrong_idx = PW'(i);
    end
    wrong_any = |wrong;

    mag   = cur_code[AW-1:0];
    legal = (mag != '0) && (mag <= AW'(MAX_STEP));

    // Both directions stay below 2N, so one conditional subtract wraps the ring.
    if (cur_code[MW-1]) begin
      sum = {1'b0, cur_q} + (PW + 1)'(mag);
    end else begin
      sum = {1'b0, cur_q} + N_EXT - (PW + 1)'(mag);
    end
    if (sum >= N_EXT) sum = sum - N_EXT;
    next_player = sum[PW-1:0];

    start_player = ({1'b0, bus.first_player} >= N_EXT) ? '0 : bus.first_player;

    move_ok      = (state_q == TURN) && !wrong_any && own_press && legal;
    timer_clear  = bus.start || move_ok;
    timer_enable = (state_q == TURN) && !own_press && !bus.start;
  end

  game_turn_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expire  (timer_expire)
  );

  // Game FSM; start wins over any press, wrong turn wins over the owner's move.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cur_q        <= '0;
      turn_valid_q <= 1'b0;
      game_over_q  <= 1'b0;
      loser_q      <= '0;
      cause_q      <= LOSE_NONE;
      count_q      <= '0;
    end else if (bus.start) begin
      state_q      <= TURN;
      cur_q        <= start_player;
      turn_valid_q <= 1'b1;
      game_over_q  <= 1'b0;
      loser_q      <= '0;
      cause_q      <= LOSE_NONE;
      count_q      <= '0;
    end else if (state_q == TURN) begin
      if (wrong_any) begin
        state_q      <= OVER;
        turn_valid_q <= 1'b0;
        game_over_q  <= 1'b1;
        loser_q      <= wrong_idx;
        cause_q      <= LOSE_WRONG;
      end else if (own_press && !legal) begin
        state_q      <= OVER;
        turn_valid_q <= 1'b0;
        game_over_q  <= 1'b1;
        loser_q      <= cur_q;
        cause_q      <= LOSE_ILLEGAL;
      end else if (own_press) begin
        cur_q <= next_player;
        if (count_q != '1) count_q <= count_q + 1'b1;
      end else if (timer_expire) begin
        state_q      <= OVER;
        turn_valid_q <= 1'b0;
        game_over_q  <= 1'b1;
        loser_q      <= cur_q;
        cause_q      <= LOSE_TIMEOUT;
      end
    end
  end

  assign bus.cur_player = cur_q;
  assign bus.turn_valid = turn_valid_q;
  assign bus.game_over  = game_over_q;
  assign bus.loser      = loser_q;
  assign bus.lose_cause = cause_q;
  assign bus.move_count = count_q;
  assign bus.state_out  = state_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Directed bench for game_turn_ctrl with 6 players, MAX_STEP 2, TIMEOUT 16.
// A table of single-cycle vectors covers the per-move behaviour; hand-written
// sequences cover timeout, counter saturation and asynchronous reset.
module tb_game_turn_ctrl;

  typedef struct {
    int          start;
    int          first_player;
    int          press;
    logic [17:0] move;
    int          cur;
    int          turn_valid;
    int          game_over;
    int          loser;
    int          cause;
    int          count;
    int          state;
  } vec_t;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  vec_t vecs[$];

  game_turn_ctrl_if #(.N_PLAYERS(6), .MAX_STEP(2), .CNT_W(8)) bus ();

  game_turn_ctrl #(
    .N_PLAYERS (6),
    .MAX_STEP  (2),
    .TIMEOUT   (16),
    .CNT_W     (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] mv(input int p, input logic [2:0] code);
    logic [17:0] r;
    r = '0;
    r[p*3 +: 3] = code;
    return r;
  endfunction

  function automatic vec_t mk(input int st, input int fp, input int pr,
                              input logic [17:0] m, input int cur, input int tv,
                              input int go, input int lo, input int ca,
                              input int cn, input int sv);
    vec_t v;
    v.start = st; v.first_player = fp; v.press = pr; v.move = m;
    v.cur = cur; v.turn_valid = tv; v.game_over = go; v.loser = lo;
    v.cause = ca; v.count = cn; v.state = sv;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input int cur, input int tv,
                          input int go, input int lo, input int ca,
                          input int cn, input int sv);
    checkOutput($sformatf("%s.cur_player", tag), int'(bus.cur_player), cur);
    checkOutput($sformatf("%s.turn_valid", tag), int'(bus.turn_valid), tv);
    checkOutput($sformatf("%s.game_over", tag), int'(bus.game_over), go);
    checkOutput($sformatf("%s.loser", tag), int'(bus.loser), lo);
    checkOutput($sformatf("%s.lose_cause", tag), int'(bus.lose_cause), ca);
    checkOutput($sformatf("%s.move_count", tag), int'(bus.move_count), cn);
    checkOutput($sformatf("%s.state_out", tag), int'(bus.state_out), sv);
  endtask

  // Drives one cycle of inputs, waits past the edge, then returns inputs to idle.
  task automatic applyStimulus(input int st, input int fp, input int pr,
                               input logic [17:0] m);
    bus.start        = st[0];
    bus.first_player = fp[2:0];
    bus.press        = pr[5:0];
    bus.move         = m;
    @(posedge clk);
    #1;
    bus.start        = 1'b0;
    bus.first_player = '0;
    bus.press        = '0;
    bus.move         = '0;
  endtask

  initial begin
    int cur_model;
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    bus.start        = 1'b0;
    bus.first_player = '0;
    bus.press        = '0;
    bus.move         = '0;

    //        st fp press      move            cur tv go lo ca cn st
    vecs.push_back(mk(0, 0, 6'b000001, mv(0, 3'b101), 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 0,         '0,            3, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,         '0,            0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6'b000001, mv(0, 3'b101), 1, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 6'b000010, mv(1, 3'b010), 5, 1, 0, 0, 0, 2, 1));
    vecs.push_back(mk(0, 0, 6'b100000, mv(5, 3'b110), 1, 1, 0, 0, 0, 3, 1));
    vecs.push_back(mk(0, 0, 6'b000010, mv(1, 3'b100), 1, 0, 1, 1, 1, 3, 2));
    vecs.push_back(mk(0, 0, 6'b000010, mv(1, 3'b101), 1, 0, 1, 1, 1, 3, 2));
    vecs.push_back(mk(0, 0, 0,         '0,            1, 0, 1, 1, 1, 3, 2));
    vecs.push_back(mk(1, 2, 0,         '0,            2, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6'b010100, mv(2, 3'b101), 2, 0, 1, 4, 2, 0, 2));
    vecs.push_back(mk(1, 2, 0,         '0,            2, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6'b010010, mv(1, 3'b101), 2, 0, 1, 1, 2, 0, 2));
    vecs.push_back(mk(1, 2, 0,         '0,            2, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6'b000100, mv(2, 3'b101), 3, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(1, 7, 6'b001000, mv(3, 3'b101), 0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6'b000001, mv(0, 3'b010), 4, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 6'b010000, mv(4, 3'b111), 4, 0, 1, 4, 1, 1, 2));
    vecs.push_back(mk(1, 6, 0,         '0,            0, 1, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 6'b000001, mv(0, 3'b110), 2, 1, 0, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 6'b000100, mv(2, 3'b011), 2, 0, 1, 2, 1, 1, 2));

    repeat (2) @(posedge clk);
    #1;
    checkAll("reset", 0, 0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].start, vecs[k].first_player, vecs[k].press, vecs[k].move);
      checkAll($sformatf("vec%0d", k), vecs[k].cur, vecs[k].turn_valid,
               vecs[k].game_over, vecs[k].loser, vecs[k].cause,
               vecs[k].count, vecs[k].state);
    end

    // Timeout: 15 idle cycles survive, the 16th ends the game.
    applyStimulus(1, 1, 0, '0);
    repeat (15) applyStimulus(0, 0, 0, '0);
    checkAll("to_before", 1, 1, 0, 0, 0, 0, 1);
    applyStimulus(0, 0, 0, '0);
    checkAll("to_fire", 1, 0, 1, 1, 3, 0, 2);

    // A legal move on the final idle cycle is taken and restarts the timer.
    applyStimulus(1, 1, 0, '0);
    repeat (15) applyStimulus(0, 0, 0, '0);
    applyStimulus(0, 0, 6'b000010, mv(1, 3'b101));
    checkAll("to_save", 2, 1, 0, 0, 0, 1, 1);
    repeat (15) applyStimulus(0, 0, 0, '0);
    checkAll("to_rearm", 2, 1, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, '0);
    checkAll("to_fire2", 2, 0, 1, 2, 3, 1, 2);

    // Move counter saturates at 255 while play continues normally.
    applyStimulus(1, 0, 0, '0);
    cur_model = 0;
    for (int k = 0; k < 260; k++) begin
      applyStimulus(0, 0, 1 << cur_model, mv(cur_model, 3'b101));
      cur_model = (cur_model + 1) % 6;
    end
    checkAll("sat", cur_model, 1, 0, 0, 0, 255, 1);

    // Asynchronous reset between edges clears outputs immediately.
    applyStimulus(1, 2, 0, '0);
    applyStimulus(0, 0, 6'b000100, mv(2, 3'b110));
    checkAll("pre_rst", 4, 1, 0, 0, 0, 1, 1);
    #3;
    reset_n = 1'b0;
    #1;
    checkAll("async_rst", 0, 0, 0, 0, 0, 0, 0);
    #2;
    reset_n = 1'b1;
    applyStimulus(0, 0, 6'b000001, mv(0, 3'b101));
    checkAll("post_rst", 0, 0, 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
